// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-RAM arbiter: port identifiers and the
// read-return tag that travels alongside each outstanding read.
package mem_arb_pkg;

   localparam logic [1:0] PORT_D = 2'd0;
   localparam logic [1:0] PORT_F = 2'd1;
   localparam logic [1:0] PORT_L = 2'd2;

   localparam int               CNT_W   = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

   typedef struct packed {
      logic       valid;
      logic [1:0] port;
   } tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Delay line of read-return tags; its depth matches the RAM read latency so
// each tag emerges in the same cycle as the data it describes.
module arb_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int RAM_LATENCY = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t tag_p [RAM_LATENCY];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < RAM_LATENCY; i++) begin
            tag_p[i] <= '0;
         end
      end else begin
         tag_p[0] <= tag_in;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            tag_p[i] <= tag_p[i-1];
         end
      end
   end

   assign tag_out = tag_p[RAM_LATENCY-1];

endmodule

// File: rtl/memory_arbiter.sv
// Three-port arbiter for a single-ported unified RAM: fixed D > F > L priority
// with starvation promotion of F and L, and tag-routed pipelined read returns.
module memory_arbiter
   import mem_arb_pkg::*;
#(
   parameter int RAM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        d_req,
   input  logic        f_req,
   input  logic        l_req,
   input  logic        d_we,
   input  logic        l_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] f_addr,
   input  logic [15:0] l_addr,
   input  logic [15:0] d_wdata,
   input  logic [15:0] l_wdata,
   output logic        d_gnt,
   output logic        f_gnt,
   output logic        l_gnt,
   output logic        d_rvalid,
   output logic        f_rvalid,
   output logic        l_rvalid,
   output logic [15:0] d_rdata,
   output logic [15:0] f_rdata,
   output logic [15:0] l_rdata,
   output logic        d_stall,
   output logic        f_stall,
   output logic        ram_en,
   output logic        ram_we,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_wdata,
   input  logic [15:0] ram_rdata
);

   localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_LIMIT);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   logic [CNT_W-1:0] cnt_f;
   logic [CNT_W-1:0] cnt_l;
   logic             post_reset;
   logic             allow;
   logic             prom_f;
   logic             prom_l;
   logic             win_vld;
   logic [1:0]       win_port;
   tag_t             push_tag;
   tag_t             ret_tag;

   // Grants stay off while reset is asserted and for the cycle that follows it.
   assign allow  = reset_n & ~post_reset;
   assign prom_f = f_req & (cnt_f >= STARVE_TH);
   assign prom_l = l_req & (cnt_l >= STARVE_TH);

   always_comb begin
      win_vld  = 1'b0;
      win_port = PORT_D;
      if (allow) begin
         if (prom_f) begin
            win_vld  = 1'b1;
            win_port = PORT_F;
         end else if (prom_l) begin
            win_vld  = 1'b1;
            win_port = PORT_L;
         end else if (d_req) begin
            win_vld  = 1'b1;
            win_port = PORT_D;
         end else if (f_req) begin
            win_vld  = 1'b1;
            win_port = PORT_F;
         end else if (l_req) begin
            win_vld  = 1'b1;
            win_port = PORT_L;
         end
      end
   end

   assign d_gnt   = win_vld & (win_port == PORT_D);
   assign f_gnt   = win_vld & (win_port == PORT_F);
   assign l_gnt   = win_vld & (win_port == PORT_L);
   assign d_stall = allow & d_req & ~d_gnt;
   assign f_stall = allow & f_req & ~f_gnt;

   always_comb begin
      ram_en    = win_vld;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (win_vld) begin
         case (win_port)
            PORT_D: begin
               ram_we    = d_we;
               ram_addr  = d_addr;
               ram_wdata = d_wdata;
            end
            PORT_F: ram_addr = f_addr;
            PORT_L: begin
               ram_we    = l_we;
               ram_addr  = l_addr;
               ram_wdata = l_wdata;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         post_reset <= 1'b1;
         cnt_f      <= '0;
         cnt_l      <= '0;
      end else begin
         post_reset <= 1'b0;
         cnt_f      <= (f_req && !f_gnt) ? sat_inc(cnt_f) : '0;
         cnt_l      <= (l_req && !l_gnt) ? sat_inc(cnt_l) : '0;
      end
   end

   // Read tag enters the delay line at grant and exits alongside ram_rdata.
   assign push_tag.valid = win_vld & ~ram_we;
   assign push_tag.port  = win_port;

   arb_tag_pipe #(
      .RAM_LATENCY(RAM_LATENCY)
   ) u_tag_pipe (
      .clk    (clk),
      .reset_n(reset_n),
      .tag_in (push_tag),
      .tag_out(ret_tag)
   );

   assign d_rvalid = allow & ret_tag.valid & (ret_tag.port == PORT_D);
   assign f_rvalid = allow & ret_tag.valid & (ret_tag.port == PORT_F);
   assign l_rvalid = allow & ret_tag.valid & (ret_tag.port == PORT_L);
   assign d_rdata  = ram_rdata;
   assign f_rdata  = ram_rdata;
   assign l_rdata  = ram_rdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised and directed bench for memory_arbiter with a behavioural RAM and
// a transaction-level reference model of arbitration and read returns.
module tb_memory_arbiter;

   localparam int LAT = 3;
   localparam int SL  = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        d_req, f_req, l_req, d_we, l_we;
   logic [15:0] d_addr, f_addr, l_addr, d_wdata, l_wdata;
   logic        d_gnt, f_gnt, l_gnt, d_rvalid, f_rvalid, l_rvalid;
   logic [15:0] d_rdata, f_rdata, l_rdata;
   logic        d_stall, f_stall, ram_en, ram_we;
   logic [15:0] ram_addr, ram_wdata, ram_rdata;

   always #5 clk = ~clk;

   memory_arbiter #(.RAM_LATENCY(LAT), .STARVE_LIMIT(SL)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .d_req(d_req), .f_req(f_req), .l_req(l_req), .d_we(d_we), .l_we(l_we),
      .d_addr(d_addr), .f_addr(f_addr), .l_addr(l_addr),
      .d_wdata(d_wdata), .l_wdata(l_wdata),
      .d_gnt(d_gnt), .f_gnt(f_gnt), .l_gnt(l_gnt),
      .d_rvalid(d_rvalid), .f_rvalid(f_rvalid), .l_rvalid(l_rvalid),
      .d_rdata(d_rdata), .f_rdata(f_rdata), .l_rdata(l_rdata),
      .d_stall(d_stall), .f_stall(f_stall),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   function automatic logic [15:0] pattern(input logic [7:0] a);
      return {a ^ 8'h5A, ~a};
   endfunction

   // Behavioural RAM: 256 words, read data appears LAT cycles after the access.
   logic        ram_init;
   logic [15:0] mem [256];
   logic [15:0] rd_pipe [LAT];

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= pattern(8'(i));
      end else if (ram_en && ram_we) begin
         mem[ram_addr[7:0]] <= ram_wdata;
      end
      rd_pipe[0] <= mem[ram_addr[7:0]];
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign ram_rdata = rd_pipe[LAT-1];

   // Reference model state
   typedef struct { int due; int port; logic [15:0] data; } ret_t;
   ret_t        rq[$];
   logic [15:0] ref_mem [256];
   int          cyc, cnt_f, cnt_l;
   bit          blocked;
   int          n_cmp, n_bad;
   int          exp_win;
   logic [2:0]  obs_gnt, obs_rv, exp_rv;
   logic [1:0]  obs_stall;
   logic [15:0] obs_rd;
   logic [38:0] exp_ctl, obs_ctl;
   logic [18:0] exp_ret, obs_ret;

   // One clock cycle: predict, sample at the falling edge, then advance the model.
   task automatic step();
      bit          allow, wr;
      int          w, rport;
      logic [15:0] a, wd, rd;
      logic [2:0]  g;
      logic [1:0]  st;
      allow = reset_n && !blocked;
      w = -1;
      if (allow) begin
         if (f_req && cnt_f >= SL)      w = 1;
         else if (l_req && cnt_l >= SL) w = 2;
         else if (d_req)                w = 0;
         else if (f_req)                w = 1;
         else if (l_req)                w = 2;
      end
      wr = 1'b0; a = '0; wd = '0;
      case (w)
         0: begin wr = d_we; a = d_addr; wd = d_wdata; end
         1: a = f_addr;
         2: begin wr = l_we; a = l_addr; wd = l_wdata; end
         default: ;
      endcase
      exp_win = w;
      g  = (w < 0) ? 3'b000 : 3'(1 << w);
      st = {allow && f_req && w != 1, allow && d_req && w != 0};
      exp_ctl = {g, st, (w >= 0), wr, a, wd};
      exp_rv = 3'b000; rd = '0; rport = 0;
      if (reset_n && rq.size() > 0 && rq[0].due == cyc) begin
         rport  = rq[0].port;
         exp_rv = 3'(1 << rport);
         rd     = rq[0].data;
      end
      exp_ret = {exp_rv, rd};
      #4;
      obs_gnt   = {l_gnt, f_gnt, d_gnt};
      obs_stall = {f_stall, d_stall};
      obs_rv    = {l_rvalid, f_rvalid, d_rvalid};
      obs_rd    = (rport == 2) ? l_rdata : (rport == 1) ? f_rdata : d_rdata;
      obs_ctl   = {obs_gnt, obs_stall, ram_en, ram_we, ram_addr, ram_wdata};
      obs_ret   = {obs_rv, (exp_rv != 3'b000) ? obs_rd : 16'h0000};
      @(posedge clk);
      if (!reset_n) begin
         cnt_f = 0; cnt_l = 0; blocked = 1'b1;
         rq.delete();
      end else begin
         blocked = 1'b0;
         if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
         if (w >= 0) begin
            if (wr) ref_mem[a[7:0]] = wd;
            else    rq.push_back('{due: cyc + LAT, port: w, data: ref_mem[a[7:0]]});
         end
         cnt_f = (f_req && w != 1) ? ((cnt_f < 15) ? cnt_f + 1 : 15) : 0;
         cnt_l = (l_req && w != 2) ? ((cnt_l < 15) ? cnt_l + 1 : 15) : 0;
      end
      cyc++;
      #1;
   endtask

   task automatic idle();
      d_req = 0; f_req = 0; l_req = 0; d_we = 0; l_we = 0;
      d_addr = '0; f_addr = '0; l_addr = '0; d_wdata = '0; l_wdata = '0;
   endtask

   task automatic test_reset();
      reset_n = 0; d_req = 1; f_req = 1; l_req = 1;
      d_addr = 16'h0005; f_addr = 16'h0006; l_addr = 16'h0007;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (obs_gnt !== 3'b000 || obs_ctl[33] !== 1'b0) begin
            n_bad++; $display("FAIL reset_hold gnt/en got %b/%b want 000/0", obs_gnt, obs_ctl[33]);
         end
         n_cmp++;
         if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL reset_ctl got %h want %h", obs_ctl, exp_ctl); end
      end
      reset_n = 1;
      step();
      n_cmp++;
      if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL reset_after_ctl got %h want %h", obs_ctl, exp_ctl); end
      step();
      n_cmp++;
      if (obs_gnt !== 3'b001) begin n_bad++; $display("FAIL reset_first_gnt got %b want 001", obs_gnt); end
      idle();
      for (int i = 0; i <= LAT; i++) begin
         step();
         n_cmp++;
         if (obs_ret !== exp_ret) begin n_bad++; $display("FAIL reset_ret got %h want %h", obs_ret, exp_ret); end
      end
   endtask

   task automatic test_priority();
      d_req = 1; f_req = 1; l_req = 1;
      d_addr = 16'h0010; f_addr = 16'h0020; l_addr = 16'h0030;
      step();
      n_cmp++;
      if (obs_gnt !== 3'b001 || obs_stall[1] !== 1'b1) begin
         n_bad++; $display("FAIL prio gnt/f_stall got %b/%b want 001/1", obs_gnt, obs_stall[1]);
      end
      n_cmp++;
      if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL prio_ctl got %h want %h", obs_ctl, exp_ctl); end
      idle();
      for (int k = 1; k <= LAT; k++) begin
         step();
         n_cmp++;
         if (obs_ret !== exp_ret) begin n_bad++; $display("FAIL prio_ret got %h want %h", obs_ret, exp_ret); end
         if (k == LAT) begin
            n_cmp++;
            if (obs_rv !== 3'b001 || obs_rd !== pattern(8'h10)) begin
               n_bad++; $display("FAIL prio_rdata got %b/%h want 001/%h", obs_rv, obs_rd, pattern(8'h10));
            end
         end
      end
   endtask

   task automatic test_starvation();
      int first_f;
      first_f = -1;
      f_req = 1; f_addr = 16'h0004;
      for (int i = 0; i < 10; i++) begin
         d_req = 1; d_addr = 16'($urandom_range(31));
         step();
         n_cmp++;
         if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL starve_ctl got %h want %h", obs_ctl, exp_ctl); end
         n_cmp++;
         if (obs_ret !== exp_ret) begin n_bad++; $display("FAIL starve_ret got %h want %h", obs_ret, exp_ret); end
         if (obs_gnt[1] && first_f < 0) first_f = i;
         if (i == 5) begin
            n_cmp++;
            if (obs_gnt !== 3'b001) begin n_bad++; $display("FAIL starve_d_regain got %b want 001", obs_gnt); end
         end
         if (exp_win == 1) f_addr = 16'($urandom_range(31));
      end
      n_cmp++;
      if (first_f != 4) begin n_bad++; $display("FAIL starve_f_cycle got %0d want 4", first_f); end
      idle();
      for (int i = 0; i <= LAT; i++) begin
         step();
         n_cmp++;
         if (obs_ret !== exp_ret) begin n_bad++; $display("FAIL starve_drain got %h want %h", obs_ret, exp_ret); end
      end
   endtask

   task automatic test_pipelined();
      logic [2:0] want;
      for (int j = 0; j < 8; j++) begin
         idle();
         if (j == 0) begin f_req = 1; f_addr = 16'h0000; end
         if (j == 1) begin d_req = 1; d_addr = 16'h0001; end
         if (j == 2) begin l_req = 1; l_addr = 16'h0002; end
         step();
         want = (j == 3) ? 3'b010 : (j == 4) ? 3'b001 : (j == 5) ? 3'b100 : 3'b000;
         n_cmp++;
         if (obs_rv !== want) begin n_bad++; $display("FAIL pipe_rvalid j=%0d got %b want %b", j, obs_rv, want); end
         if (want != 3'b000) begin
            n_cmp++;
            if (obs_rd !== pattern(8'(j - 3))) begin
               n_bad++; $display("FAIL pipe_rdata j=%0d got %h want %h", j, obs_rd, pattern(8'(j - 3)));
            end
         end
         n_cmp++;
         if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL pipe_ctl got %h want %h", obs_ctl, exp_ctl); end
      end
   endtask

   task automatic test_write_read();
      for (int j = 0; j <= LAT + 2; j++) begin
         idle();
         if (j == 0) begin l_req = 1; l_we = 1; l_addr = 16'h0040; l_wdata = 16'hBEEF; end
         if (j == 1) begin d_req = 1; d_addr = 16'h0040; end
         step();
         n_cmp++;
         if (obs_rv[2] !== 1'b0) begin n_bad++; $display("FAIL wr_no_lrvalid got %b want 0", obs_rv[2]); end
         n_cmp++;
         if (obs_ret !== exp_ret) begin n_bad++; $display("FAIL wr_ret got %h want %h", obs_ret, exp_ret); end
         if (j == 1 + LAT) begin
            n_cmp++;
            if (obs_rv !== 3'b001 || obs_rd !== 16'hBEEF) begin
               n_bad++; $display("FAIL wr_readback got %b/%h want 001/beef", obs_rv, obs_rd);
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 15; i++) begin
         idle();
         reset_n = !(i == 4 || i == 5);
         d_req = (i <= 10); d_addr = 16'(16'h0010 + i);
         f_req = (i <= 10); f_addr = 16'h0003;
         step();
         n_cmp++;
         if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL mid_ctl i=%0d got %h want %h", i, obs_ctl, exp_ctl); end
         n_cmp++;
         if (obs_ret !== exp_ret) begin n_bad++; $display("FAIL mid_ret i=%0d got %h want %h", i, obs_ret, exp_ret); end
         if (i >= 4 && i <= 9) begin
            n_cmp++;
            if (obs_rv !== 3'b000) begin n_bad++; $display("FAIL mid_dropped i=%0d got %b want 000", i, obs_rv); end
         end
         if (i >= 7 && i <= 10) begin
            n_cmp++;
            if (obs_gnt !== ((i == 10) ? 3'b010 : 3'b001)) begin
               n_bad++; $display("FAIL mid_cnt_clear i=%0d got %b want %b", i, obs_gnt, (i == 10) ? 3'b010 : 3'b001);
            end
         end
      end
   endtask

   task automatic test_random();
      idle();
      for (int i = 0; i < 400; i++) begin
         if (!d_req) begin
            d_req = ($urandom_range(3) != 0); d_we = 1'($urandom_range(1));
            d_addr = 16'($urandom_range(31)); d_wdata = 16'($urandom);
         end else if ($urandom_range(15) == 0) d_req = 0;
         if (!f_req) begin
            f_req = 1'($urandom_range(1)); f_addr = 16'($urandom_range(31));
         end else if ($urandom_range(15) == 0) f_req = 0;
         if (!l_req) begin
            l_req = 1'($urandom_range(1)); l_we = 1'($urandom_range(1));
            l_addr = 16'($urandom_range(31)); l_wdata = 16'($urandom);
         end else if ($urandom_range(15) == 0) l_req = 0;
         step();
         n_cmp++;
         if (obs_ctl !== exp_ctl) begin n_bad++; $display("FAIL rand_ctl i=%0d got %h want %h", i, obs_ctl, exp_ctl); end
         n_cmp++;
         if (obs_ret !== exp_ret) begin n_bad++; $display("FAIL rand_ret i=%0d got %h want %h", i, obs_ret, exp_ret); end
         if (exp_win == 0) d_req = 0;
         if (exp_win == 1) f_req = 0;
         if (exp_win == 2) l_req = 0;
      end
      idle();
      for (int i = 0; i <= LAT; i++) begin
         step();
         n_cmp++;
         if (obs_ret !== exp_ret) begin n_bad++; $display("FAIL rand_drain got %h want %h", obs_ret, exp_ret); end
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; cnt_f = 0; cnt_l = 0; blocked = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = pattern(8'(i));
      ram_init = 1; reset_n = 0;
      idle();
      @(posedge clk);
      #1;
      ram_init = 0;
      test_reset();
      test_priority();
      test_starvation();
      test_pipelined();
      test_write_read();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
